// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Size encodings, FSM states and the latched access bundle.
package dmem_arbiter_pkg;

    localparam int DMEM_WORDS = 4096;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic        port;
        logic        we;
        logic        uns;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

endpackage

// File: rtl/dmem_arbiter_lane.sv
// Byte-lane steering: write mask, replicated store data,
// load extraction with extension, and alignment check.
module dmem_lane
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rd,
    output logic [3:0]  mask,
    output logic [31:0] wd,
    output logic [31:0] ld,
    output logic        misal
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = mem_rd[{addr, 3'b000} +: 8];
    assign h = mem_rd[{addr[1], 4'b0000} +: 16];

    always_comb begin
        mask  = 4'b0000;
        wd    = wdata;
        ld    = mem_rd;
        misal = 1'b0;
        unique case (1'b1)
            (size == SZ_BYTE): begin
                mask = 4'b0001 << addr;
                wd   = {4{wdata[7:0]}};
                ld   = {{24{b[7] & ~uns}}, b};
            end
            (size == SZ_HALF): begin
                mask  = 4'b0011 << addr;
                wd    = {2{wdata[15:0]}};
                ld    = {{16{h[15] & ~uns}}, h};
                misal = addr[0];
            end
            (size == SZ_WORD): begin
                mask  = 4'b1111;
                misal = (addr != 2'b00);
            end
            default: begin
                mask = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the core LSU (port 0) and DMA
// (port 1) onto a single-ported data memory; 3 cycles per access.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DMEM_WORDS = dmem_arbiter_pkg::DMEM_WORDS
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [1:0]  uns,
    input  logic [3:0]  size,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [32:0] ADDR_LIM = 33'(DMEM_WORDS) << 2;

    state_t      state, state_nx;
    acc_t        cur, cur_nx, cand;
    logic        last, last_nx;
    logic        sel;
    logic [31:0] rd_q, rd_nx;
    logic        err_q, err_nx;
    logic        bad;

    logic [3:0]  l_mask;
    logic [31:0] l_wd;
    logic [31:0] l_ld;
    logic        l_misal;

    dmem_lane u_lane (
        .size   (cur.size),
        .addr   (cur.addr[1:0]),
        .uns    (cur.uns),
        .wdata  (cur.wdata),
        .mem_rd (mem_rd),
        .mask   (l_mask),
        .wd     (l_wd),
        .ld     (l_ld),
        .misal  (l_misal)
    );

    assign mem_a  = cur.addr;
    assign mem_wd = l_wd;

    assign bad = l_misal
               | (cur.size == SZ_ILL)
               | ({1'b0, cur.addr} >= ADDR_LIM);

    // Contention goes to the port that did not win last time.
    always_comb begin
        sel = 1'b0;
        unique case (1'b1)
            (req == 2'b11): sel = ~last;
            (req == 2'b10): sel = 1'b1;
            default:        sel = 1'b0;
        endcase
    end

    always_comb begin
        cand.port  = sel;
        cand.we    = sel ? we[1]          : we[0];
        cand.uns   = sel ? uns[1]         : uns[0];
        cand.size  = sel ? size[3:2]      : size[1:0];
        cand.addr  = sel ? addr[63:32]    : addr[31:0];
        cand.wdata = sel ? wdata[63:32]   : wdata[31:0];
    end

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        last_nx  = last;
        rd_nx    = rd_q;
        err_nx   = err_q;
        gnt      = 2'b00;
        rvalid   = 2'b00;
        rdata    = 32'h0;
        err      = 1'b0;
        mem_we   = 4'b0000;
        unique case (state)
            IDLE: begin
                if ((req != 2'b00) && !rst) begin
                    gnt      = sel ? 2'b10 : 2'b01;
                    cur_nx   = cand;
                    last_nx  = sel;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                mem_we   = (cur.we && !bad) ? l_mask : 4'b0000;
                rd_nx    = (cur.we || bad) ? 32'h0 : l_ld;
                err_nx   = bad;
                state_nx = RESP;
            end
            RESP: begin
                rvalid   = cur.port ? 2'b10 : 2'b01;
                rdata    = rd_q;
                err      = err_q;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cur   <= '0;
            last  <= 1'b1;
            rd_q  <= 32'h0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cur   <= cur_nx;
            last  <= last_nx;
            rd_q  <= rd_nx;
            err_q <= err_nx;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array reference model checked every
// cycle, plus directed accesses with literal expected results.
module tb_dmem_arbiter;

    localparam int WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we, uns;
    logic [3:0]  size;
    logic [63:0] addr, wdata;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem   [0:WORDS-1];
    logic [7:0]  ref_b [0:4*WORDS-1];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DMEM_WORDS(WORDS)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .uns    (uns),
        .size   (size),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .err    (err),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[13:2]];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (mem_we[k]) mem[mem_a[13:2]][8*k +: 8] <= mem_wd[8*k +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within bound", name);
    endtask

    function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a >= 32'(4 * WORDS)) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    // Reference model state.
    int          m_phase = 0;
    bit          m_last  = 1'b1;
    int          t_port;
    bit          t_we, t_uns;
    logic [1:0]  t_size;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] m_a = 0, m_wd = 0, m_rd = 0;
    bit          m_err = 1'b0;
    bit          m_wd_ok = 1'b1;

    always @(negedge clk) begin
        logic [1:0]  e_gnt, e_rv;
        logic [3:0]  e_we;
        logic [31:0] e_rd;
        logic        e_err;
        int          p, n;
        bit          resp;
        if (rst) begin
            chk("rst_gnt",    32'(gnt),    32'h0);
            chk("rst_rvalid", 32'(rvalid), 32'h0);
            chk("rst_rdata",  rdata,       32'h0);
            chk("rst_err",    32'(err),    32'h0);
            chk("rst_mem_we", 32'(mem_we), 32'h0);
            chk("rst_mem_a",  mem_a,       32'h0);
            chk("rst_mem_wd", mem_wd,      32'h0);
            m_phase = 0;
            m_last  = 1'b1;
            m_a     = 0;
            m_wd    = 0;
            m_wd_ok = 1'b1;
        end else begin
            e_gnt = 0; e_rv = 0; e_we = 0; e_rd = 0; e_err = 0;
            resp = 1'b0;
            case (m_phase)
                0: begin
                    if (req != 2'b00) begin
                        if (req == 2'b11) p = m_last ? 0 : 1;
                        else              p = req[1] ? 1 : 0;
                        e_gnt[p] = 1'b1;
                        m_last   = p[0];
                        t_port   = p;
                        t_we     = we[p];
                        t_uns    = uns[p];
                        t_size   = size[2*p +: 2];
                        t_addr   = addr[32*p +: 32];
                        t_wdata  = wdata[32*p +: 32];
                        m_phase  = 1;
                    end
                end
                1: begin
                    n       = 1 << t_size;
                    m_a     = t_addr;
                    m_wd_ok = (t_size != 2'd3);
                    m_wd    = (t_size == 2'd0) ? {4{t_wdata[7:0]}} :
                              (t_size == 2'd1) ? {2{t_wdata[15:0]}} : t_wdata;
                    m_err   = is_bad(t_size, t_addr);
                    m_rd    = 0;
                    if (!m_err && t_we) begin
                        e_we = 4'(((1 << n) - 1) << t_addr[1:0]);
                        for (int i = 0; i < n; i++)
                            ref_b[t_addr + i] = t_wdata[8*i +: 8];
                    end else if (!m_err) begin
                        for (int i = 0; i < n; i++)
                            m_rd[8*i +: 8] = ref_b[t_addr + i];
                        if (!t_uns && m_rd[8*n-1])
                            for (int i = n; i < 4; i++) m_rd[8*i +: 8] = 8'hFF;
                    end
                    m_phase = 2;
                end
                default: begin
                    e_rv[t_port] = 1'b1;
                    e_rd    = m_rd;
                    e_err   = m_err;
                    resp    = 1'b1;
                    m_phase = 0;
                end
            endcase
            chk("gnt",    32'(gnt),    32'(e_gnt));
            chk("rvalid", 32'(rvalid), 32'(e_rv));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_a",  mem_a,       m_a);
            if (m_wd_ok) chk("mem_wd", mem_wd, m_wd);
            if (resp) begin
                chk("rdata", rdata,    e_rd);
                chk("err",   32'(err), 32'(e_err));
            end
        end
    end

    task automatic access(input int p, input bit w, input bit u,
                          input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic e, output logic [3:0] wem,
                          output logic [31:0] wdv, output int lat);
        int n;
        @(posedge clk); #1;
        req[p] = 1'b1;
        we[p]  = w;
        uns[p] = u;
        size[2*p +: 2]   = sz;
        addr[32*p +: 32]  = a;
        wdata[32*p +: 32] = d;
        rd = 0; e = 0; wem = 0; wdv = 0; lat = -1;
        n = 0;
        @(negedge clk);
        while (!gnt[p] && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!gnt[p]) begin
            timeout("gnt_wait");
            req[p] = 1'b0;
            return;
        end
        @(posedge clk); #1 req[p] = 1'b0;
        for (n = 1; n < 10; n++) begin
            @(negedge clk);
            wem |= mem_we;
            if (n == 1) wdv = mem_wd;
            if (rvalid[p]) begin
                rd  = rdata;
                e   = err;
                lat = n;
                break;
            end
        end
        if (lat < 0) timeout("rvalid_wait");
    endtask

    initial begin
        logic [31:0] rd, wdv;
        logic        e;
        logic [3:0]  wem;
        int          lat, n, rvcnt;
        int          gp[$];
        int          gc[$];

        for (int i = 0; i < WORDS; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i);
            for (int k = 0; k < 4; k++)
                ref_b[4*i + k] = mem[i][8*k +: 8];
        end

        rst   = 1'b1;
        req   = 2'b11;
        we    = 2'b00;
        uns   = 2'b00;
        size  = 4'b1010;
        addr  = {32'h20, 32'h24};
        wdata = 64'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Both ports requesting continuously from reset.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (gnt[0]) begin gp.push_back(0); gc.push_back(c); end
            if (gnt[1]) begin gp.push_back(1); gc.push_back(c); end
        end
        @(posedge clk); #1 req = 2'b00;
        repeat (4) @(posedge clk);
        chk("rr_count", 32'(gp.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gp.size()) begin
                chk("rr_port",  32'(gp[i]), 32'(i % 2));
                chk("rr_cycle", 32'(gc[i]), 32'(3 * i));
            end
        end

        access(0, 1, 0, 2'b10, 32'h10, 32'hDEADBEEF, rd, e, wem, wdv, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_we",  32'(wem), 32'hF);
        chk("sw_err", 32'(e),   32'h0);
        access(0, 0, 0, 2'b10, 32'h10, 32'h0, rd, e, wem, wdv, lat);
        chk("lw_10", rd, 32'hDEADBEEF);

        access(1, 1, 0, 2'b00, 32'h13, 32'hA5, rd, e, wem, wdv, lat);
        chk("sb_we", 32'(wem), 32'h8);
        chk("sb_wd", wdv,      32'hA5A5A5A5);
        access(1, 0, 0, 2'b00, 32'h13, 32'h0, rd, e, wem, wdv, lat);
        chk("lb_s", rd, 32'hFFFFFFA5);
        access(0, 0, 1, 2'b00, 32'h13, 32'h0, rd, e, wem, wdv, lat);
        chk("lb_u", rd, 32'h000000A5);

        access(0, 1, 0, 2'b01, 32'h21, 32'hBEEF, rd, e, wem, wdv, lat);
        chk("sh_mis_err", 32'(e),   32'h1);
        chk("sh_mis_rd",  rd,       32'h0);
        chk("sh_mis_we",  32'(wem), 32'h0);
        access(1, 0, 0, 2'b10, 32'h4000, 32'h0, rd, e, wem, wdv, lat);
        chk("lw_oob_err", 32'(e),   32'h1);
        chk("lw_oob_rd",  rd,       32'h0);
        chk("lw_oob_we",  32'(wem), 32'h0);
        access(0, 0, 0, 2'b11, 32'h30, 32'h0, rd, e, wem, wdv, lat);
        chk("ill_err", 32'(e), 32'h1);
        access(0, 0, 0, 2'b10, 32'h20, 32'h0, rd, e, wem, wdv, lat);
        chk("lw_20_kept", rd, 32'h10000008);

        access(1, 1, 0, 2'b01, 32'h22, 32'h8001, rd, e, wem, wdv, lat);
        chk("sh_we", 32'(wem), 32'hC);
        chk("sh_wd", wdv,      32'h80018001);
        access(0, 0, 0, 2'b01, 32'h22, 32'h0, rd, e, wem, wdv, lat);
        chk("lh_s", rd, 32'hFFFF8001);

        access(0, 1, 0, 2'b10, 32'h8, 32'hCAFEF00D, rd, e, wem, wdv, lat);
        chk("sw_8_err", 32'(e), 32'h0);

        // Reset lands in the BUSY cycle of a store to 0x8.
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; size[1:0] = 2'b10;
        addr[31:0] = 32'h8; wdata[31:0] = 32'h12345678;
        n = 0;
        @(negedge clk);
        while (!gnt[0] && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!gnt[0]) timeout("rst_gnt_wait");
        @(posedge clk); #1;
        req[0] = 1'b0;
        rst    = 1'b1;
        #1;
        chk("rst_now_we", 32'(mem_we), 32'h0);
        chk("rst_now_a",  mem_a,       32'h0);
        chk("rst_now_wd", mem_wd,      32'h0);
        @(posedge clk); #1 rst = 1'b0;
        rvcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (rvalid != 2'b00) rvcnt++;
        end
        chk("rst_no_rvalid", 32'(rvcnt), 32'h0);
        access(0, 0, 0, 2'b10, 32'h8, 32'h0, rd, e, wem, wdv, lat);
        chk("lw_8_prior", rd, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DMEM_WORDS, default 4096, number of 32-bit words in the data memory; byte address range is 0 .. 4*DMEM_WORDS-1.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req  in  2  per-port request, bit i = port i (port 0 = core LSU, port 1 = DMA); held high until granted.
REQ-005 we  in  2  per-port write flag (1 = store, 0 = load).
REQ-006 uns  in  2  per-port unsigned-load flag (1 = zero-extend, 0 = sign-extend).
REQ-007 size  in  4  per-port access size, [2i+1:2i]: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 addr  in  64  per-port byte address, [32i+31:32i].
REQ-009 wdata  in  64  per-port store data, right-justified, [32i+31:32i].
REQ-010 gnt  out  2  one-cycle pulse; the request on port i is accepted this cycle.
REQ-011 rvalid  out  2  one-cycle pulse; the response for port i is valid this cycle.
REQ-012 rdata  out  32  load result, right-justified and extended; 0 for stores and errors.
REQ-013 err  out  1  qualifies rvalid; high = access rejected.
REQ-014 mem_we  out  4  byte write mask to the data memory.
REQ-015 mem_a  out  32  byte address to the data memory.
REQ-016 mem_wd  out  32  lane-replicated write data to the data memory.
REQ-017 mem_rd  in  32  asynchronous read data from the data memory for mem_a.

Function
REQ-018 FSM states: IDLE, BUSY, RESP; each access takes 3 cycles; gnt is asserted only in IDLE.
REQ-019 IDLE, any req high: pulse the chosen gnt bit; latch that port's we, uns, size, addr and wdata; go to BUSY. IDLE, no req: stay in IDLE.
REQ-020 Arbitration is round-robin. With one requester, grant it. With both requesting, grant the port not granted last. The last-grant register resets to 1, so port 0 wins the first contention.
REQ-021 BUSY: drive mem_a with the latched addr and mem_wd with the latched wdata replicated (byte x4, half x2, word as-is).
REQ-022 BUSY: drive mem_we = 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word). Drive mem_we = 0 for loads and errors.
REQ-023 BUSY: register mem_rd at the clock edge that ends BUSY; a store commits at that same edge; go to RESP.
REQ-024 RESP: pulse rvalid for the latched port for one cycle, drive rdata and err, then return to IDLE.
REQ-025 Load extraction: byte = mem_rd[8*addr[1:0]+:8]; half = mem_rd[16*addr[1]+:16]; result is sign- or zero-extended per uns.
REQ-026 Error cases: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr >= 4*DMEM_WORDS.
REQ-027 An erroring access still passes through BUSY and RESP with mem_we = 0, and responds err = 1, rdata = 0.
REQ-028 Outside BUSY: mem_we = 0. mem_a and mem_wd hold their last values.
REQ-029 A req that drops before gnt is not an error. Requests arriving in BUSY or RESP wait until the next IDLE.

Reset
REQ-030 While rst is high, outputs are: gnt = 0, rvalid = 0, rdata = 0, err = 0, mem_we = 0, mem_a = 0, mem_wd = 0; FSM = IDLE; last-grant = 1.
REQ-031 Reset asserted mid-access aborts the access: no write commits after the reset edge and no response is issued.

Structure
REQ-032 A shared package holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and DMEM_WORDS.
REQ-033 One sub-module, dmem_lane: purely combinational; maps size, addr, wdata and mem_rd to the byte mask, replicated write data, extracted load data and misalignment flag.

Verification
REQ-034 Stimulus: port 0 word store, addr 0x10, wdata 0xDEADBEEF. Required: gnt[0] in cycle 0; mem_we = 1111 and mem_a = 0x10 in cycle 1; rvalid[0] with err = 0 in cycle 2. A following word load of 0x10 returns 0xDEADBEEF.
REQ-035 Stimulus: port 1 byte store of 0xA5 to addr 0x13. Required: mem_we = 1000 and mem_wd = 0xA5A5A5A5. Then a signed byte load of 0x13 returns 0xFFFFFFA5, and an unsigned one returns 0x000000A5.
REQ-036 Stimulus: both ports request continuously from reset. Required: grants alternate 0,1,0,1, one grant every 3 cycles.
REQ-037 Stimulus: half store to addr 0x21, and word load from addr 0x4000. Required: each has mem_we = 0 throughout, and responds err = 1, rdata = 0; memory is unchanged.
REQ-038 Stimulus: rst asserted during BUSY of a word store to 0x8. Required: all outputs 0 immediately, no rvalid is issued, and a later load of 0x8 returns the prior contents.
